// File: rtl/fifo_rd_packetizer.sv
// Purpose: pops the dual-clock FIFO read port and emits fixed-length packets on a valid/ready stream.
// Latency: FIFO non-empty to m_valid is 1 rclk cycle; 1 word/cycle sustained.
// Backpressure: 2-entry skid buffer; fifo_rinc depends only on registered state, never on m_ready.
//
// Ports:
//   rclk, rrst              clock and synchronous active-high reset
//   en                      run request; a stop takes effect only at a packet boundary
//   fifo_rdata, fifo_rempty FIFO head word and empty flag
//   fifo_rinc               FIFO pop strobe
//   m_valid/m_ready/m_data  output stream; m_last marks beat PKT_LEN-1
//   busy                    FSM not idle
//   stat_words, stat_starve statistics, present only when FIFO_STATS_EN is defined (else 0)
module fifo_rd_packetizer #(
  parameter int DSIZE   = 16,
  parameter int PKT_LEN = 8,
  parameter int CW      = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             en,
  input  logic [DSIZE-1:0] fifo_rdata,
  input  logic             fifo_rempty,
  output logic             fifo_rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic [31:0]      stat_words,
  output logic [15:0]      stat_starve
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH, DRAIN} state_t;

  localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);

  state_t           state, state_nxt;
  logic [DSIZE-1:0] buf0, buf1;   // buf0 is the head entry
  logic [1:0]       cnt;
  logic [CW-1:0]    fetch_cnt, fetch_cnt_nxt, beat_cnt;
  logic             fetching, push, pop;

  assign fetching  = (state == RUN) || (state == FINISH);
  // Only registered state and the FIFO flag: the skid buffer absorbs m_ready.
  assign fifo_rinc = fetching & ~fifo_rempty & (cnt != 2'd2);
  assign push      = fifo_rinc;
  assign m_valid   = (cnt != 2'd0);
  assign pop       = m_valid & m_ready;
  assign m_data    = buf0;
  assign m_last    = m_valid & (beat_cnt == LAST);
  assign busy      = (state != IDLE);

  assign fetch_cnt_nxt = !push ? fetch_cnt :
                         (fetch_cnt == LAST) ? '0 : fetch_cnt + CW'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      // Stop lands on DRAIN directly if this edge completes the packet's fetches.
      RUN:     if (!en) state_nxt = (fetch_cnt_nxt == '0) ? DRAIN : FINISH;
      FINISH:  if (fetch_cnt_nxt == '0) state_nxt = DRAIN;
      DRAIN: begin
        if (en)                         state_nxt = RUN;
        else if (cnt == 2'd0 && !push)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      buf0      <= '0;
      buf1      <= '0;
      fetch_cnt <= '0;
      beat_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      fetch_cnt <= fetch_cnt_nxt;
      if (pop) beat_cnt <= (beat_cnt == LAST) ? '0 : beat_cnt + CW'(1);
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) buf0 <= fifo_rdata;
          else             buf1 <= fifo_rdata;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          cnt  <= cnt - 2'd1;
        end
        // push requires cnt!=2 and pop requires cnt!=0, so cnt==1 here.
        2'b11:   buf0 <= fifo_rdata;
        default: ;
      endcase
    end
  end

`ifdef FIFO_STATS_EN
  logic [31:0] words_q;
  logic [15:0] starve_q;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      words_q  <= '0;
      starve_q <= '0;
    end else begin
      if (pop) words_q <= words_q + 32'd1;
      if (fetching && fifo_rempty && cnt == 2'd0 && starve_q != 16'hFFFF)
        starve_q <= starve_q + 16'd1;
    end
  end

  assign stat_words  = words_q;
  assign stat_starve = starve_q;
`else
  assign stat_words  = '0;
  assign stat_starve = '0;
`endif

endmodule
